hsst_line_unpack: RTL and testbench
===================================

// Module: hsst_line_unpack
// PURPOSE
//  Read-side consumer of the 16-bit HSST prefetch FIFO, on that FIFO's rd_clk domain.
//  Finds line sync, decodes the line tag, packs LINE_WORDS payload words into
//  OUT_W-bit beats and presents them with valid/ready to the DDR write path.
//  Lost sync and bad tags are counted; the block then re-hunts.
// PARAMETERS
//  DATA_W     16       FIFO word width
//  PACK       8        words per output beat; OUT_W = DATA_W*PACK (derived)
//  LINE_WORDS 640      payload words per line; multiple of PACK, max 65535
//  SYNC_WORD  16'hBCBC line sync marker
// PORTS
//  rd_clk      in   1      single clock
//  rd_rst      in   1      asynchronous reset, active-high
//  fifo_rd_en  out  1      pop FIFO word; combinational
//  fifo_rd_vld in   1      FIFO word valid (prefetch: data present before pop)
//  fifo_rd_data in  DATA_W FIFO head word
//  out_data    out  OUT_W  packed beat; first word received in [DATA_W-1:0]
//  out_valid   out  1      beat valid
//  out_ready   in   1      sink accepts beat
//  out_sof     out  1      beat is first of line whose tag bit15=1 (frame start)
//  out_sol     out  1      beat is first of line
//  out_eol     out  1      beat is last of line
//  out_line    out  11     line number from tag, held for whole line
//  err_cnt     out  16     bad-tag count, saturating
// BEHAVIOUR
//  Reset: all outputs 0; state HUNT; pack register, word counter, err_cnt cleared.
//  Word accepted = fifo_rd_en & fifo_rd_vld. fifo_rd_en never high when fifo_rd_vld=0.
//  States:
//   HUNT: fifo_rd_en=fifo_rd_vld; discard words; accepted SYNC_WORD -> TAG.
//   TAG: fifo_rd_en=fifo_rd_vld; on accepted word w:
//    w==SYNC_WORD -> stay TAG (repeated sync tolerated, no error)
//    w[14:11]!=0 -> err_cnt+1 (saturate 16'hFFFF) -> HUNT
//    else latch out_line=w[10:0], frame flag=w[15], word_cnt=0 -> PAYLOAD
//   PAYLOAD: every word is data, SYNC_WORD included. Word goes into slot word_cnt%PACK.
//    Last word of a beat moves the beat into the output register.
//    After LINE_WORDS words -> HUNT.
//  Stall: PAYLOAD with slot==PACK-1, out_valid=1 and out_ready=0 -> fifo_rd_en=0.
//   Beat with slots 0..PACK-2 filled is held in the pack register without loss.
//  Output register: loaded in the cycle the last word of a beat is accepted.
//   out_valid rises the next cycle, so latency is 1 clk from last word to out_valid.
//  Full throughput: new beat may load the same cycle out_valid&out_ready retires the old one.
//  out_data/sof/sol/eol/out_line stable while out_valid=1 and out_ready=0.
//  out_sol=1 on beat 0 of line; out_eol=1 on beat LINE_WORDS/PACK-1.
//   Both are set when LINE_WORDS==PACK.
//  out_line/sof belong to the beat's line even if the next tag arrives while the beat is stalled.
//  HUNT/TAG of the next line proceed while the final beat waits in the output register.
//  Reset mid-line: partial beat and pending output dropped; resume in HUNT.
// TESTING (LINE_WORDS=16, PACK=8)
//  T1 stream BCBC,8005,0001..0010 -> 2 beats: beat0 data 0008..0001 (0001 in LSB)
//   with sof=sol=1, line=5; beat1 eol=1; err_cnt=0.
//  T2 junk 1234,5678 then BCBC,BCBC,0007,16 words -> junk dropped; one line, line=7, sof=0.
//  T3 out_ready=0 for 20 clks mid-line -> fifo_rd_en=0 after 7 words are held.
//   out_data stable; no word lost or duplicated after release.
//  T4 fifo_rd_vld toggles every cycle -> same beats as T1; out_valid 1 clk after 8th word.
//  T5 tag 0x0805 -> err_cnt=1, state HUNT; following good line unpacked correctly.
//   Force err_cnt to FFFF, send one more bad tag -> err_cnt stays FFFF.
//  T6 rd_rst pulse after 11 payload words -> out_valid=0 immediately.
//   Next complete line output is correct with sol=1.

Source files
------------

// File: rtl/hsst_line_unpack_if.sv
// Bundles the prefetch-FIFO read port and the packed-beat output stream of hsst_line_unpack.
// master is the unpacker's view; slave is the FIFO/sink environment's view.
interface hsst_line_unpack_if #(
  parameter int DATA_W = 16,
  parameter int PACK   = 8
);
  localparam int OUT_W = DATA_W * PACK;

  logic              fifo_rd_en;
  logic              fifo_rd_vld;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_sol;
  logic              out_eol;
  logic [10:0]       out_line;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_vld,
    input  fifo_rd_data,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_sof,
    output out_sol,
    output out_eol,
    output out_line
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_vld,
    output fifo_rd_data,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_sof,
    input  out_sol,
    input  out_eol,
    input  out_line
  );
endinterface

// File: rtl/hsst_line_unpack.sv
// Hunts line sync in the HSST prefetch FIFO stream, decodes the line tag and packs
// the payload words into wide beats for the DDR write path.
module hsst_line_unpack #(
  parameter int              DATA_W     = 16,
  parameter int              PACK       = 8,
  parameter int              LINE_WORDS = 640,
  parameter logic [DATA_W-1:0] SYNC_WORD = 16'hBCBC
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  hsst_line_unpack_if.master   bus,
  output logic [15:0]          err_cnt
);

  localparam int OUT_W  = DATA_W * PACK;
  localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] TAG     = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;

  logic [1:0]        state;
  logic [SLOT_W-1:0] slot;
  logic [15:0]       word_cnt;
  logic [DATA_W-1:0] pack_reg [PACK];
  logic [10:0]       line_reg;
  logic              frame_reg;

  logic              last_slot;
  logic              last_word;
  logic              stall;
  logic              accept;
  logic              load;
  logic              retire;
  logic [OUT_W-1:0]  beat_data;

  // The closing word of a beat is only popped once the output register can take it,
  // so a stalled line keeps its partial beat in pack_reg and the word stays in the FIFO.
  always_comb begin
    last_slot      = (slot == SLOT_W'(PACK - 1));
    last_word      = (word_cnt == 16'(LINE_WORDS - 1));
    stall          = (state == PAYLOAD) && last_slot && bus.out_valid && !bus.out_ready;
    bus.fifo_rd_en = bus.fifo_rd_vld && !stall;
    accept         = bus.fifo_rd_en && bus.fifo_rd_vld;
    load           = accept && (state == PAYLOAD) && last_slot;
    retire         = bus.out_valid && bus.out_ready;
    beat_data      = '0;
    for (int i = 0; i < PACK; i++) begin
      beat_data[i*DATA_W +: DATA_W] = (i == PACK - 1) ? bus.fifo_rd_data : pack_reg[i];
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state     <= HUNT;
      slot      <= '0;
      word_cnt  <= '0;
      line_reg  <= '0;
      frame_reg <= 1'b0;
      err_cnt   <= '0;
    end else if (accept) begin
      case (state)
        HUNT: begin
          if (bus.fifo_rd_data == SYNC_WORD) state <= TAG;
        end
        TAG: begin
          if (bus.fifo_rd_data == SYNC_WORD) begin
            state <= TAG;
          end else if (bus.fifo_rd_data[14:11] != 4'd0) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            state <= HUNT;
          end else begin
            line_reg  <= bus.fifo_rd_data[10:0];
            frame_reg <= bus.fifo_rd_data[15];
            word_cnt  <= '0;
            slot      <= '0;
            state     <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (last_word) begin
            word_cnt <= '0;
            slot     <= '0;
            state    <= HUNT;
          end else begin
            word_cnt <= word_cnt + 16'd1;
            slot     <= last_slot ? '0 : slot + SLOT_W'(1);
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int i = 0; i < PACK; i++) pack_reg[i] <= '0;
    end else if (accept && (state == PAYLOAD)) begin
      pack_reg[slot] <= bus.fifo_rd_data;
    end
  end

  // Line number and frame flag travel with the beat, so a following tag cannot alter a stalled beat.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sof   <= 1'b0;
      bus.out_sol   <= 1'b0;
      bus.out_eol   <= 1'b0;
      bus.out_line  <= '0;
    end else if (load) begin
      bus.out_data  <= beat_data;
      bus.out_valid <= 1'b1;
      bus.out_sof   <= frame_reg;
      bus.out_sol   <= (word_cnt == 16'(PACK - 1));
      bus.out_eol   <= last_word;
      bus.out_line  <= line_reg;
    end else if (retire) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hsst_line_unpack.sv
// Directed bench for hsst_line_unpack: a FIFO source, a stream-level line parser as
// reference model, and a monitor comparing every retired beat against it.
module tb_hsst_line_unpack;

  localparam int          DW   = 16;
  localparam int          PK   = 8;
  localparam int          LW   = 16;
  localparam logic [15:0] SYNC = 16'hBCBC;

  typedef struct packed {
    logic [127:0] data;
    logic         sof;
    logic         sol;
    logic         eol;
    logic [10:0]  line;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] err_cnt;

  hsst_line_unpack_if #(.DATA_W(DW), .PACK(PK)) bus ();

  hsst_line_unpack #(
    .DATA_W(DW), .PACK(PK), .LINE_WORDS(LW), .SYNC_WORD(SYNC)
  ) dut (
    .rd_clk (clk),
    .rd_rst (rst),
    .bus    (bus.master),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int          total_cnt = 0;
  int          bad_cnt   = 0;
  int          cyc       = 0;
  logic [15:0] src_q[$];
  logic [15:0] wl[$];
  beat_t       exp_q[$];
  beat_t       got_q[$];
  logic [15:0] m_err = 16'd0;
  bit          toggle_mode = 1'b0;
  bit          gate = 1'b1;
  int          pop_cnt = 0;
  int          eighth_cyc = -100;
  int          first_valid_cyc = -1;
  bit          hold_pending = 1'b0;
  beat_t       held;

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] expv);
    total_cnt++;
    if (act !== expv) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic failNow(input string name);
    total_cnt++;
    bad_cnt++;
    $display("[TB] FAIL %s", name);
  endtask

  // Reference: scan the word list for sync, skip repeated syncs, judge the tag and cut
  // LINE_WORDS payload words into beats; only complete beats are expected.
  task automatic model_parse();
    int          i;
    int          n;
    int          avail;
    logic [15:0] tag;
    beat_t       bt;
    i = 0;
    n = wl.size();
    while (i < n) begin
      if (wl[i] != SYNC) begin
        i++;
        continue;
      end
      i++;
      while (i < n && wl[i] == SYNC) i++;
      if (i >= n) break;
      tag = wl[i];
      i++;
      if (tag[14:11] != 4'd0) begin
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        continue;
      end
      avail = (n - i < LW) ? n - i : LW;
      for (int b = 0; (b + 1) * PK <= avail; b++) begin
        bt.data = '0;
        for (int k = 0; k < PK; k++) bt.data[k*16 +: 16] = wl[i + b*PK + k];
        bt.sof  = tag[15];
        bt.sol  = (b == 0);
        bt.eol  = (b == LW/PK - 1);
        bt.line = tag[10:0];
        exp_q.push_back(bt);
      end
      i += avail;
    end
  endtask

  task automatic add_line(input logic [15:0] tag, input logic [15:0] base, input int nwords);
    wl.push_back(SYNC);
    wl.push_back(tag);
    for (int k = 1; k <= nwords; k++) wl.push_back(base + 16'(k));
  endtask

  task automatic applyStimulus();
    foreach (wl[j]) src_q.push_back(wl[j]);
    model_parse();
    wl.delete();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(src_q.size() == 0 && exp_q.size() == 0 && !bus.out_valid) && n < 2000);
    if (n >= 2000) failNow({name, "_timeout"});
    checkOutput({name, "_err_cnt"}, 160'(err_cnt), 160'(m_err));
  endtask

  task automatic at_drive_slot();
    @(posedge clk);
    #3;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FIFO source: a word counts as popped if rd_en&rd_vld held across the edge.
  initial begin
    bit acc;
    int acc_cyc;
    bus.fifo_rd_vld  = 1'b0;
    bus.fifo_rd_data = '0;
    forever begin
      @(negedge clk);
      acc     = bus.fifo_rd_en && bus.fifo_rd_vld && !rst;
      acc_cyc = cyc;
      if (bus.fifo_rd_en && !bus.fifo_rd_vld) failNow("rd_en_without_vld");
      @(posedge clk);
      #1;
      if (acc && src_q.size() > 0) begin
        void'(src_q.pop_front());
        pop_cnt++;
        if (pop_cnt == 10) eighth_cyc = acc_cyc;
      end
      gate             = toggle_mode ? ~gate : 1'b1;
      bus.fifo_rd_vld  = (src_q.size() > 0) && gate;
      bus.fifo_rd_data = (src_q.size() > 0) ? src_q[0] : 16'h0000;
    end
  end

  // Beat monitor: every retired beat against the model, and held beats must not move.
  initial begin
    beat_t cur;
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pending = 1'b0;
      end else begin
        cur = {bus.out_data, bus.out_sof, bus.out_sol, bus.out_eol, bus.out_line};
        if (hold_pending) checkOutput("stall_hold", {bus.out_valid, cur}, {1'b1, held});
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            failNow("unexpected_beat");
          end else begin
            e = exp_q.pop_front();
            checkOutput("beat", cur, e);
          end
          got_q.push_back(cur);
        end
        hold_pending = bus.out_valid && !bus.out_ready;
        held         = cur;
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("rst_out_valid", 160'(bus.out_valid), 160'(0));
    checkOutput("rst_out_data", 160'(bus.out_data), 160'(0));
    checkOutput("rst_flags", 160'({bus.out_sof, bus.out_sol, bus.out_eol, bus.out_line}), 160'(0));
    checkOutput("rst_err_cnt", 160'(err_cnt), 160'(0));
    checkOutput("rst_rd_en", 160'(bus.fifo_rd_en), 160'(0));
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;

    $display("[TB] T1 basic line");
    got_q.delete();
    add_line(16'h8005, 16'h0000, 16);
    applyStimulus();
    wait_idle("t1");
    checkOutput("t1_beats", 160'(got_q.size()), 160'(2));
    if (got_q.size() == 2) begin
      checkOutput("t1_b0_data", 160'(got_q[0].data), 160'(128'h0008_0007_0006_0005_0004_0003_0002_0001));
      checkOutput("t1_b0_flags", 160'({got_q[0].sof, got_q[0].sol, got_q[0].eol, got_q[0].line}), 160'({3'b110, 11'd5}));
      checkOutput("t1_b1_data", 160'(got_q[1].data), 160'(128'h0010_000F_000E_000D_000C_000B_000A_0009));
      checkOutput("t1_b1_flags", 160'({got_q[1].sol, got_q[1].eol}), 160'(2'b01));
    end
    checkOutput("t1_err_lit", 160'(err_cnt), 160'(0));

    $display("[TB] T2 junk and repeated sync");
    got_q.delete();
    wl.push_back(16'h1234);
    wl.push_back(16'h5678);
    wl.push_back(SYNC);
    add_line(16'h0007, 16'h0300, 16);
    applyStimulus();
    wait_idle("t2");
    checkOutput("t2_beats", 160'(got_q.size()), 160'(2));
    if (got_q.size() == 2) begin
      checkOutput("t2_b0_flags", 160'({got_q[0].sof, got_q[0].sol, got_q[0].line}), 160'({2'b01, 11'd7}));
      checkOutput("t2_b0_data", 160'(got_q[0].data), 160'(128'h0308_0307_0306_0305_0304_0303_0302_0301));
    end

    $display("[TB] T3 output stall");
    got_q.delete();
    at_drive_slot();
    bus.out_ready = 1'b0;
    pop_cnt = 0;
    add_line(16'h0009, 16'h0200, 16);
    applyStimulus();
    repeat (25) @(negedge clk);
    checkOutput("t3_popped", 160'(pop_cnt), 160'(17));
    checkOutput("t3_rd_en", 160'(bus.fifo_rd_en), 160'(0));
    checkOutput("t3_valid", 160'(bus.out_valid), 160'(1));
    at_drive_slot();
    bus.out_ready = 1'b1;
    wait_idle("t3");
    checkOutput("t3_beats", 160'(got_q.size()), 160'(2));
    if (got_q.size() == 2)
      checkOutput("t3_b1_data", 160'(got_q[1].data), 160'(128'h0210_020F_020E_020D_020C_020B_020A_0209));

    $display("[TB] T4 gapped FIFO");
    got_q.delete();
    at_drive_slot();
    toggle_mode     = 1'b1;
    pop_cnt         = 0;
    first_valid_cyc = -1;
    add_line(16'h8005, 16'h0000, 16);
    applyStimulus();
    wait_idle("t4");
    toggle_mode = 1'b0;
    checkOutput("t4_latency", 160'(first_valid_cyc), 160'(eighth_cyc + 1));
    checkOutput("t4_beats", 160'(got_q.size()), 160'(2));
    if (got_q.size() == 2) begin
      checkOutput("t4_b0_data", 160'(got_q[0].data), 160'(128'h0008_0007_0006_0005_0004_0003_0002_0001));
      checkOutput("t4_b1_data", 160'(got_q[1].data), 160'(128'h0010_000F_000E_000D_000C_000B_000A_0009));
    end

    $display("[TB] T5 bad tag and saturation");
    got_q.delete();
    at_drive_slot();
    wl.push_back(SYNC);
    wl.push_back(16'h0805);
    add_line(16'h0003, 16'h0100, 16);
    applyStimulus();
    wait_idle("t5");
    checkOutput("t5_err_lit", 160'(err_cnt), 160'(1));
    checkOutput("t5_beats", 160'(got_q.size()), 160'(2));
    if (got_q.size() == 2)
      checkOutput("t5_b0_line", 160'(got_q[0].line), 160'(3));
    at_drive_slot();
    force dut.err_cnt = 16'hFFFF;
    @(posedge clk);
    #2;
    release dut.err_cnt;
    m_err = 16'hFFFF;
    wl.push_back(SYNC);
    wl.push_back(16'h7805);
    applyStimulus();
    wait_idle("t5_sat");
    checkOutput("t5_sat_lit", 160'(err_cnt), 160'(16'hFFFF));

    $display("[TB] T6 reset mid-line");
    got_q.delete();
    at_drive_slot();
    bus.out_ready = 1'b0;
    add_line(16'h8002, 16'h0500, 11);
    applyStimulus();
    n = 0;
    while (src_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) failNow("t6_fill_timeout");
    repeat (3) @(negedge clk);
    at_drive_slot();
    checkOutput("t6_valid_before", 160'(bus.out_valid), 160'(1));
    rst = 1'b1;
    hold_pending = 1'b0;
    src_q.delete();
    bus.fifo_rd_vld = 1'b0;
    #1;
    checkOutput("t6_valid_in_rst", 160'(bus.out_valid), 160'(0));
    exp_q.delete();
    m_err = 16'd0;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    add_line(16'h8004, 16'h0400, 16);
    applyStimulus();
    wait_idle("t6");
    checkOutput("t6_beats", 160'(got_q.size()), 160'(2));
    if (got_q.size() == 2) begin
      checkOutput("t6_b0_flags", 160'({got_q[0].sof, got_q[0].sol, got_q[0].line}), 160'({2'b11, 11'd4}));
      checkOutput("t6_b0_data", 160'(got_q[0].data), 160'(128'h0408_0407_0406_0405_0404_0403_0402_0401));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
